sseg_dev: RTL and testbench

Serial driver for the board's 8-digit seven-segment display, which sits behind a 74HC164-style shift-register chain. It renders 8 hex nibbles with per-digit decimal points and per-digit blanking into a 64-bit frame. On each rising edge of `Start`, it shifts the frame out over a clock/data pair and then re-enables the display. The top level instantiates it to show score (digit 6) and health (digit 0).

---
 rtl/sseg_pkg.sv | 18 +
 rtl/sseg_dev_hex7seg.sv | 22 ++
 rtl/sseg_dev.sv | 115 +++++++++++
 tb/tb_sseg_dev.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment serial driver: segment table, blank code, FSM states.
package sseg_pkg;

  // Active-low {dp, g, f, e, d, c, b, a} codes for nibbles 0..F, dp off.
  localparam logic [7:0] SegTable [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // All segments and the decimal point dark.
  localparam logic [7:0] BlankCode = 8'hFF;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/sseg_dev_hex7seg.sv
// One digit of the frame: nibble to active-low segment byte with decimal point and blanking.
module hex7seg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  // Blanking wins over the decimal point.
  always_comb begin
    seg = SegTable[nibble];
    if (dp) begin
      seg[7] = 1'b0;
    end
    if (blank) begin
      seg = BlankCode;
    end
  end

endmodule

// File: rtl/sseg_dev.sv
// Serial driver for an 8-digit seven-segment display behind a 74HC164-style shift chain.
// A rising edge on Start shifts a 64-bit frame out MSB first, then re-enables the display.
module sseg_dev
  import sseg_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Start,
  input  logic        flash,
  input  logic [31:0] Hexs,
  input  logic [7:0]  point,
  input  logic [7:0]  LES,
  output logic        seg_clk,
  output logic        seg_clrn,
  output logic        seg_sout,
  output logic        SEG_PEN
);

  localparam int unsigned HcW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HcW-1:0] HcLast = HcW'(HALF_PERIOD - 1);

  logic [1:0]     sync_q;
  logic           prev_q;
  logic [1:0]     settle_q;
  logic           go_q;
  logic [63:0]    frame_d;
  logic [63:0]    frame_q;
  logic [5:0]     bit_cnt_q;
  logic [HcW-1:0] half_cnt_q;
  logic           seg_clk_q;
  logic           pen_q;
  state_e         state_q;

  // Synchronize Start and emit a one-cycle go pulse on its rising edge. Edges are ignored until
  // the pipeline has refilled after reset, so a Start already high at release never fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= 2'b00;
      prev_q   <= 1'b0;
      settle_q <= 2'd0;
      go_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], Start};
      prev_q <= sync_q[1];
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      go_q <= (settle_q == 2'd3) & sync_q[1] & ~prev_q;
    end
  end

  // Digit i occupies frame bits [8i+7:8i]; digit 7 goes out first.
  for (genvar i = 0; i < 8; i++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (Hexs[4*i +: 4]),
      .dp     (point[i]),
      .blank  (LES[i] & flash),
      .seg    (frame_d[8*i +: 8])
    );
  end

  // Frame FSM: latch on go, then shift each bit low-half/high-half on seg_clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      seg_clk_q  <= 1'b0;
      pen_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (go_q) begin
            frame_q    <= frame_d;
            bit_cnt_q  <= 6'd63;
            half_cnt_q <= '0;
            seg_clk_q  <= 1'b0;
            pen_q      <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          if (half_cnt_q != HcLast) begin
            half_cnt_q <= half_cnt_q + HcW'(1);
          end else begin
            half_cnt_q <= '0;
            if (!seg_clk_q) begin
              seg_clk_q <= 1'b1;
            end else begin
              // Data only moves as seg_clk falls, so it is stable across every rising edge.
              seg_clk_q <= 1'b0;
              if (bit_cnt_q == 6'd0) begin
                pen_q   <= 1'b1;
                state_q <= StIdle;
              end else begin
                bit_cnt_q <= bit_cnt_q - 6'd1;
                frame_q   <= {frame_q[62:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign seg_clk  = seg_clk_q;
  assign seg_sout = frame_q[63];
  assign SEG_PEN  = pen_q;
  assign seg_clrn = rstn;

endmodule

// File: tb/tb_sseg_dev.sv
// Bench for sseg_dev: HALF_PERIOD=1 and HALF_PERIOD=3 instances against a frame model.
module tb_sseg_dev;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [1:0]  start = 2'b00;
  logic        flash = 1'b0;
  logic [31:0] Hexs = '0;
  logic [7:0]  point = '0;
  logic [7:0]  LES = '0;
  logic [1:0]  sclk, clrn, sout, pen;

  int checks = 0;
  int failures = 0;

  logic [63:0] cap [2];
  int          edges [2];
  int          pen_rises [2];
  int          hold_viol [2];
  logic [1:0]  prev_sout = 2'b00;

  always #5 clk = ~clk;

  sseg_dev #(.HALF_PERIOD(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .Start(start[0]), .flash(flash), .Hexs(Hexs), .point(point),
    .LES(LES), .seg_clk(sclk[0]), .seg_clrn(clrn[0]), .seg_sout(sout[0]), .SEG_PEN(pen[0])
  );

  sseg_dev #(.HALF_PERIOD(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .Start(start[1]), .flash(flash), .Hexs(Hexs), .point(point),
    .LES(LES), .seg_clk(sclk[1]), .seg_clrn(clrn[1]), .seg_sout(sout[1]), .SEG_PEN(pen[1])
  );

  initial begin
    for (int d = 0; d < 2; d++) begin
      cap[d] = '0; edges[d] = 0; pen_rises[d] = 0; hold_viol[d] = 0;
    end
  end

  // External shift register model: sample data on each rising seg_clk.
  always @(posedge sclk[0]) begin
    cap[0] = {cap[0][62:0], sout[0]};
    edges[0] = edges[0] + 1;
  end
  always @(posedge sclk[1]) begin
    cap[1] = {cap[1][62:0], sout[1]};
    edges[1] = edges[1] + 1;
  end
  always @(posedge pen[0]) pen_rises[0] = pen_rises[0] + 1;
  always @(posedge pen[1]) pen_rises[1] = pen_rises[1] + 1;

  // Data must not move while seg_clk is high.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rstn && sclk[d] === 1'b1 && sout[d] !== prev_sout[d]) hold_viol[d] = hold_viol[d] + 1;
      prev_sout[d] = sout[d];
    end
  end

  function automatic logic [63:0] model(input logic [31:0] h, input logic [7:0] p,
                                        input logic [7:0] l, input logic f);
    logic [7:0]  tbl [16];
    logic [7:0]  b;
    logic [3:0]  nib;
    logic [63:0] m;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    m = '0;
    for (int i = 7; i >= 0; i--) begin
      nib = h[4*i +: 4];
      b = tbl[nib];
      if (p[i]) b = b & 8'h7F;
      if (l[i] && f) b = 8'hFF;
      m = {m[55:0], b};
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One frame on instance d; inputs are scrambled once shifting starts to prove they were latched.
  task automatic run_frame(input int d, input logic [31:0] h, input logic [7:0] p,
                           input logic [7:0] l, input logic f, input logic [63:0] exp,
                           input bit retrig, input string tag);
    int  hp;
    int  e0, r0, n;
    time ts, tf, tp;
    hp = (d == 1) ? 3 : 1;
    @(negedge clk);
    Hexs = h; point = p; LES = l; flash = f;
    e0 = edges[d]; r0 = pen_rises[d];
    start[d] = 1'b1;
    ts = $time;
    n = 0;
    while (edges[d] == e0 && n < 50) begin @(negedge clk); n++; end
    tf = $time - 5;
    check({tag, " latency"}, tf - ts, (3 + hp) * 10 + 5);
    check({tag, " pen_low"}, pen[d], 0);
    Hexs = $urandom; point = 8'($urandom); LES = 8'($urandom); flash = 1'($urandom);
    if (retrig) begin
      n = 0;
      while (edges[d] - e0 < 20 && n < 100) begin @(negedge clk); n++; end
      start[d] = 1'b0;
      repeat (3) @(negedge clk);
      start[d] = 1'b1;
    end
    n = 0;
    while (pen_rises[d] == r0 && n < 200 * hp) begin @(negedge clk); n++; end
    tp = $time - 5;
    if (retrig) repeat (300) @(negedge clk);
    check({tag, " frame"}, cap[d], exp);
    check({tag, " edges"}, edges[d] - e0, 64);
    check({tag, " idle_count"}, pen_rises[d] - r0, 1);
    check({tag, " length"}, tp - tf, 127 * hp * 10);
    check({tag, " end_state"}, {sclk[d], pen[d]}, 2'b01);
    start[d] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] h;
    logic [7:0]  p, l;
    logic        f;
    int          e0, r0, n;

    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {sclk, sout, pen, clrn}, 8'h00);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset", {sclk, sout, pen, clrn}, 8'h03);

    run_frame(0, 32'h0400_0003, 8'h41, 8'h00, 1'b0, model(32'h0400_0003, 8'h41, 8'h00, 1'b0),
              1'b0, "basic");
    run_frame(0, 32'h0123_4567, 8'h00, 8'h00, 1'b0, 64'hC0F9A4B0_999282F8, 1'b0, "codes_lo");
    run_frame(0, 32'h89AB_CDEF, 8'h00, 8'h00, 1'b1, 64'h80908883_C6A1868E, 1'b0, "codes_hi");
    run_frame(0, 32'h0, 8'h01, 8'h01, 1'b1, 64'hC0C0C0C0_C0C0C0FF, 1'b0, "blink_on");
    run_frame(0, 32'h0, 8'h01, 8'h01, 1'b0, 64'hC0C0C0C0_C0C0C040, 1'b0, "blink_off");
    run_frame(0, 32'hDEAD_BEEF, 8'hA5, 8'h0F, 1'b1, model(32'hDEAD_BEEF, 8'hA5, 8'h0F, 1'b1),
              1'b1, "retrigger");

    // Reset partway through a frame, with Start held high across release.
    @(negedge clk);
    Hexs = 32'h1234_5678; point = 8'hFF; LES = 8'h00; flash = 1'b0;
    e0 = edges[0];
    start[0] = 1'b1;
    n = 0;
    while (edges[0] - e0 < 30 && n < 200) begin @(negedge clk); n++; end
    #2 rstn = 1'b0;
    #1 check("reset_mid_shift", {sclk, sout, pen, clrn}, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    e0 = edges[0]; r0 = pen_rises[0];
    repeat (300) @(negedge clk);
    check("held_start_edges", edges[0] - e0, 0);
    check("held_start_pen", {pen[0], pen_rises[0] - r0}, 0);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    run_frame(0, 32'h1234_5678, 8'hFF, 8'h00, 1'b0, model(32'h1234_5678, 8'hFF, 8'h00, 1'b0),
              1'b0, "after_reset");

    run_frame(1, 32'h89AB_CDEF, 8'h00, 8'h00, 1'b0, 64'h80908883_C6A1868E, 1'b0, "hp3_codes");
    for (int k = 0; k < 2; k++) begin
      h = $urandom; p = 8'($urandom); l = 8'($urandom); f = 1'($urandom);
      run_frame(1, h, p, l, f, model(h, p, l, f), 1'b0, "hp3_random");
    end
    for (int k = 0; k < 6; k++) begin
      h = $urandom; p = 8'($urandom); l = 8'($urandom); f = 1'($urandom);
      run_frame(0, h, p, l, f, model(h, p, l, f), 1'b0, "random");
    end

    check("hold_hp1", hold_viol[0], 0);
    check("hold_hp3", hold_viol[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
